// File: rtl/block_checker.sv
// Streaming begin/end nesting checker: one ASCII character per clock, result=1
// while the keywords seen so far are balanced and no unmatched "end" has occurred.
module block_checker #(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    output logic       result
);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_B     = 4'd1,
        ST_BE    = 4'd2,
        ST_BEG   = 4'd3,
        ST_BEGI  = 4'd4,
        ST_BEGIN = 4'd5,
        ST_E     = 4'd6,
        ST_EN    = 4'd7,
        ST_END   = 4'd8,
        ST_SKIP  = 4'd9
    } state_t;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_B     = 8'h62;
    localparam logic [7:0] CH_E     = 8'h65;
    localparam logic [7:0] CH_G     = 8'h67;
    localparam logic [7:0] CH_I     = 8'h69;
    localparam logic [7:0] CH_N     = 8'h6E;
    localparam logic [7:0] CH_D     = 8'h64;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W+1:0] EFF_ONE  = {{(CNT_W+1){1'b0}}, 1'b1};
    localparam logic [CNT_W+1:0] EFF_ZERO = {(CNT_W+2){1'b0}};

    function automatic logic [7:0] to_lower(input logic [7:0] c);
        if (c >= 8'h41 && c <= 8'h5A) begin
            return c + 8'h20;
        end else begin
            return c;
        end
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             dead_r;
    logic             dead_s;
    logic             result_r;
    logic             result_s;
    logic [7:0]       lc_s;
    logic [CNT_W+1:0] eff_s;

    assign lc_s   = to_lower(in);
    assign result = result_r;

    // State, counter, sticky failure flag and registered status bit
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            dead_r   <= 1'b0;
            result_r <= 1'b1;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            dead_r   <= dead_s;
            result_r <= result_s;
        end
    end

    // Word recognition plus commit of a finished keyword on its terminating space
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        dead_s  = dead_r;
        if (lc_s == CH_SPACE) begin
            state_s = ST_IDLE;
            case (state_r)
                ST_BEGIN: begin
                    if (cnt_r == CNT_MAX) begin
                        cnt_s = cnt_r;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                ST_END: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_s = cnt_r - CNT_ONE;
                    end else begin
                        dead_s = 1'b1;
                    end
                end
                default: begin
                    cnt_s = cnt_r;
                end
            endcase
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (lc_s == CH_B) begin
                        state_s = ST_B;
                    end else if (lc_s == CH_E) begin
                        state_s = ST_E;
                    end else begin
                        state_s = ST_SKIP;
                    end
                end
                ST_B:    state_s = (lc_s == CH_E) ? ST_BE   : ST_SKIP;
                ST_BE:   state_s = (lc_s == CH_G) ? ST_BEG  : ST_SKIP;
                ST_BEG:  state_s = (lc_s == CH_I) ? ST_BEGI : ST_SKIP;
                ST_BEGI: state_s = (lc_s == CH_N) ? ST_BEGIN : ST_SKIP;
                ST_E:    state_s = (lc_s == CH_N) ? ST_EN   : ST_SKIP;
                ST_EN:   state_s = (lc_s == CH_D) ? ST_END  : ST_SKIP;
                default: state_s = ST_SKIP;
            endcase
        end
    end

    // Tentative effective count of the upcoming state; result is registered from it
    always_comb begin
        case (state_s)
            ST_BEGIN: eff_s = {2'b00, cnt_s} + EFF_ONE;
            ST_END:   eff_s = {2'b00, cnt_s} - EFF_ONE;
            default:  eff_s = {2'b00, cnt_s};
        endcase
        result_s = !dead_s && (eff_s == EFF_ZERO);
    end

endmodule

// File: tb/tb_block_checker.sv
// Bench for block_checker: directed scenarios plus random word streams, each
// character checked against a word-buffer reference model.
module tb_block_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in;
    logic       result;

    int errors = 0;
    int checks = 0;

    longint m_cnt;
    bit     m_dead;
    byte    m_buf [0:7];
    int     m_len;

    block_checker #(.CNT_W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (in),
        .result (result)
    );

    always #5 clk = ~clk;

    function automatic byte lower(input byte c);
        if (c >= 8'h41 && c <= 8'h5A) return byte'(c + 8'h20);
        else return c;
    endfunction

    function automatic bit word_is(input string k);
        if (m_len != k.len()) return 1'b0;
        for (int i = 0; i < k.len(); i++)
            if (m_buf[i] != k[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit model_result();
        longint eff;
        eff = m_cnt;
        if (word_is("begin")) eff = eff + 1;
        else if (word_is("end")) eff = eff - 1;
        return !m_dead && (eff == 0);
    endfunction

    task automatic model_reset();
        m_cnt  = 0;
        m_dead = 1'b0;
        m_len  = 0;
    endtask

    task automatic model_char(input byte c);
        if (c == 8'h20) begin
            if (word_is("begin")) m_cnt = m_cnt + 1;
            else if (word_is("end")) begin
                if (m_cnt > 0) m_cnt = m_cnt - 1;
                else m_dead = 1'b1;
            end
            m_len = 0;
        end else begin
            if (m_len < 8) m_buf[m_len] = lower(c);
            m_len++;
        end
    endtask

    task automatic check(input string tag, input bit exp);
        checks++;
        assert (result === exp) else begin
            errors++;
            $error("FAIL %s: result=%0b expected=%0b", tag, result, exp);
        end
    endtask

    task automatic step(input byte c);
        @(negedge clk);
        in = c;
        @(posedge clk);
        #1;
        model_char(c);
        check($sformatf("char_0x%02h", c), model_result());
    endtask

    task automatic feed(input string s);
        for (int i = 0; i < s.len(); i++) step(s[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in    = 8'h65;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        check("reset", 1'b1);
    endtask

    string words [12] = '{"begin", "end", "BeGiN", "END", "ends", "beginx",
                          "xend", "foo", "b", "en", "begi", "eNdB"};
    string alpha = "bBeEgGiInNdDx  ";

    initial begin
        reset = 1'b0;
        in    = 8'h20;
        model_reset();
        do_reset();

        // begin / end balanced pair
        feed("begi"); step(8'h6E); check("begin_n", 1'b0);
        step(8'h20); check("begin_sp", 1'b0);
        feed("en"); step(8'h64); check("end_d", 1'b1);
        step(8'h20); check("end_sp", 1'b1);

        // unmatched end makes the failure sticky
        do_reset();
        feed("en"); step(8'h64); check("lone_end_d", 1'b0);
        step(8'h20); check("lone_end_sp", 1'b0);
        feed("begin end "); check("dead_sticky", 1'b0);

        // tentative end reverted by a following letter
        do_reset();
        feed("eNd"); check("eNd_tentative", 1'b0);
        step(8'h42); check("eNdB_revert", 1'b1);
        feed(" begin bEGIn end "); check("cnt_one", 1'b0);

        // non-keyword words containing keywords
        do_reset();
        feed("begin begin  eNdBbegin "); check("cnt_two", 1'b0);
        do_reset();
        feed("ends beginx xend "); check("non_keywords", 1'b1);

        // mid-stream reset clears dead
        feed("end "); check("dead_again", 1'b0);
        do_reset();
        feed("BEGIN END "); check("after_reset", 1'b1);

        // random keyword-rich word streams
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            feed(words[$urandom_range(0, 11)]);
            repeat ($urandom_range(1, 2)) step(8'h20);
        end

        // random character soup
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            step(alpha[$urandom_range(0, alpha.len() - 1)]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
